// File: rtl/button_debouncer.sv
// Multi-channel debouncer with rising/falling edge pulses.
// Shared sample tick gates per-channel saturating counters.
`timescale 1ns/100ps
module button_debouncer #(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam int SW = $clog2(SAMPLE_CNT_MAX);
  localparam int PW = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [SW-1:0] SLAST = SW'(SAMPLE_CNT_MAX - 1);
  localparam logic [PW-1:0] PMAX  = PW'(PULSE_CNT_MAX);

  logic [SW-1:0]    r_sample_cnt;
  logic             w_tick;
  logic [PW-1:0]    r_sat_cnt [WIDTH];
  logic [WIDTH-1:0] r_deb_q;

  assign w_tick = (r_sample_cnt == SLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_cnt <= '0;
    end else if (w_tick) begin
      r_sample_cnt <= '0;
    end else begin
      r_sample_cnt <= r_sample_cnt + SW'(1);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    // A single low sample clears the count, whether or not it is a tick.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sat_cnt[g] <= '0;
      end else if (!glitchy_signal[g]) begin
        r_sat_cnt[g] <= '0;
      end else if (w_tick && (r_sat_cnt[g] < PMAX)) begin
        r_sat_cnt[g] <= r_sat_cnt[g] + PW'(1);
      end
    end

    assign debounced_signal[g] = (r_sat_cnt[g] == PMAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb_q <= '0;
    end else begin
      r_deb_q <= debounced_signal;
    end
  end

  assign rise_pulse = debounced_signal & ~r_deb_q;
  assign fall_pulse = ~debounced_signal & r_deb_q;

endmodule
